sine_gen: RTL
=============

SINE_GEN -- requirements
Module: sine_gen

Interface
REQ-001 SHALL have parameters: PHASE_W, default 24, phase accumulator width; DIV, default 1042, clk_clk cycles per sample tick (50 MHz -> ~48 kHz); ROM_AW, default 8, quarter-wave ROM address width.
REQ-002 SHALL have ports: clk_clk  in  1  single system clock, all logic on rising edge.
REQ-003 reset_reset_n  in  1  synchronous, active-low reset.
REQ-004 enable  in  1  run request, level.
REQ-005 freq_word  in  PHASE_W  phase increment per sample.
REQ-006 freq_load  in  1  one-cycle strobe capturing freq_word.
REQ-007 phase_clr  in  1  one-cycle strobe zeroing the accumulator.
REQ-008 lrck  in  1  asynchronous codec DACLRCK tap, used only with the Configuration macro.
REQ-009 sin_out  out  32  {sample[15:0], sample[15:0]} stereo word feeding the processor's sin_in PIO.
REQ-010 sample_valid  out  1  one-cycle pulse when sin_out updates.

Function
REQ-011 States: IDLE (enable=0) and RUN (enable=1); IDLE->RUN and RUN->IDLE on the enable level, evaluated every cycle.
REQ-012 Tick (internal): counter 0..DIV-1 in RUN; tick asserted when counter==DIV-1, counter then wraps to 0; counter held at 0 in IDLE.
REQ-013 On tick: stage 0 latches phase, then phase <= phase + inc, modulo 2^PHASE_W, carry discarded.
REQ-014 Stage 1 (tick+1): quadrant q = latched phase[MSB:MSB-1]; addr = next ROM_AW bits, bitwise inverted when q[0]=1.
REQ-015 Stage 2 (tick+2): registered ROM read; ROM[i] = round(32767*sin((i+0.5)*pi/(2*2^ROM_AW))), 16-bit signed, all values positive.
REQ-016 Stage 3 (tick+3): sample = -ROM when q[1]=1, otherwise +ROM; sin_out updated and sample_valid pulsed in the same cycle.
REQ-017 Latency: tick to sample_valid is exactly 3 cycles; the pipeline accepts one tick per cycle and no overflow is possible (|sample|<=32767).
REQ-018 freq_load: inc <= freq_word on that cycle; if it coincides with a tick, that tick uses the old inc.
REQ-019 phase_clr: phase <= 0; it has priority over a coincident tick (phase becomes 0, not 0+inc); in-flight samples are unaffected.
REQ-020 enable falling mid-pipeline: in-flight samples complete and pulse sample_valid; no new ticks are accepted; phase and inc are retained.
REQ-021 In IDLE, sin_out holds its last value.

Reset
REQ-022 On reset_reset_n=0 at a clock edge: phase, inc, tick counter, pipeline valid bits, sin_out and sample_valid SHALL all be 0; state SHALL be IDLE.
REQ-023 Reset mid-pipeline SHALL discard in-flight samples, with no sample_valid pulse after reset is released.

Configuration
REQ-024 Macro SINE_GEN_EXT_TICK_EN defined: the divider is removed; lrck passes through a 2-flop synchroniser and tick = synchronised rising edge of lrck, gated by RUN.
REQ-025 Macro absent: lrck is unused and tick comes from the DIV counter of REQ-012.

Structure
REQ-026 Package sine_gen_pkg SHALL hold the PHASE_W/ROM_AW/DIV defaults, the state enum type and the 16-bit sample typedef.
REQ-027 Sub-module sine_rom (quarter-wave table, registered output) SHALL be instantiated once; the ROM contents are generated from a constant function or an init file.

Verification
REQ-028 freq_word=0, freq_load, enable, DIV=4 -> sin_out=0x00650065 (ROM[0]=101) with sample_valid every 4 cycles.
REQ-029 freq_word=0x400000 -> samples repeat 101, 32767, -101, -32767 (sin_out 0x00650065, 0x7FFF7FFF, 0xFF9BFF9B, 0x80018001).
REQ-030 Single tick -> sample_valid exactly 3 cycles later, 1 cycle wide; 3 back-to-back ticks (DIV=1) -> 3 consecutive pulses.
REQ-031 freq_load of 0x400000 on a tick cycle with old inc=0 -> next sample still uses phase 0; the following sample uses quadrant 1.
REQ-032 phase_clr coincident with a tick during 0x400000 run -> next latched phase is 0 (sample 101); reset asserted one cycle after a tick -> no sample_valid, all outputs 0.
REQ-033 With SINE_GEN_EXT_TICK_EN: lrck toggling at 48 kHz, asynchronous to clk_clk -> exactly one sample_valid per lrck rising edge, 5-6 cycles after the edge (2-3 for sync and edge detect, 3 for the pipeline).

Source files
------------

// File: rtl/sine_gen_pkg.sv
// Shared defaults and types for the sine_gen block: parameter defaults,
// run/idle state type and the signed sample type.
package sine_gen_pkg;
    localparam int PHASE_W_DEF = 24;
    localparam int DIV_DEF     = 1042;
    localparam int ROM_AW_DEF  = 8;
    localparam int STAGES      = 3;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    typedef logic signed [15:0] sample_t;
endpackage

// File: rtl/sine_gen_if.sv
// Control/data bundle of sine_gen: frequency and phase controls in,
// stereo sample word and its valid pulse out.
interface sine_gen_if #(parameter int PHASE_W = 24) ();
    logic               enable;
    logic [PHASE_W-1:0] freq_word;
    logic               freq_load;
    logic               phase_clr;
    logic [31:0]        sin_out;
    logic               sample_valid;

    modport master (output enable, freq_word, freq_load, phase_clr,
                    input  sin_out, sample_valid);
    modport slave  (input  enable, freq_word, freq_load, phase_clr,
                    output sin_out, sample_valid);
endinterface

// File: rtl/sine_rom.sv
// Quarter-wave sine table, 2^ROM_AW entries of round(32767*sin((i+0.5)*pi/2/N)),
// built at elaboration from a Taylor series; one-cycle registered read.
module sine_rom
    import sine_gen_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEF
) (
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output sample_t           data
);
    localparam int  DEPTH = 1 << ROM_AW;
    localparam real PI    = 3.14159265358979323846;

    function automatic logic [DEPTH*16-1:0] gen_table();
        logic [DEPTH*16-1:0] t;
        real x, term, acc;
        t = '0;
        for (int i = 0; i < DEPTH; i++) begin
            x    = (real'(i) + 0.5) * PI / (2.0 * real'(DEPTH));
            term = x;
            acc  = x;
            // x <= pi/2, so 12 odd terms are far below one LSB of error
            for (int k = 1; k < 12; k++) begin
                term = -term * x * x / real'((2 * k) * (2 * k + 1));
                acc  = acc + term;
            end
            t[i*16 +: 16] = 16'($rtoi(32767.0 * acc + 0.5));
        end
        return t;
    endfunction

    localparam logic [DEPTH*16-1:0] TABLE = gen_table();

    always_ff @(posedge clk) begin
        data <= sample_t'(TABLE[{addr, 4'b0000} +: 16]);
    end
endmodule

// File: rtl/sine_gen.sv
// DDS sine generator: phase accumulator stepped on sample ticks, quarter-wave ROM,
// 3-cycle tick-to-sample pipeline. SINE_GEN_EXT_TICK_EN takes ticks from lrck edges.
module sine_gen
    import sine_gen_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int DIV     = DIV_DEF,
    parameter int ROM_AW  = ROM_AW_DEF
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       lrck,
    sine_gen_if.slave  bus
);
    state_t               state_q, state_d;
    logic                 tick;
    logic [PHASE_W-1:0]   phase, inc;
    logic [ROM_AW+1:0]    ph_lat;
    logic [1:0]           quad, quad_q;
    logic [ROM_AW-1:0]    addr;
    sample_t              rom_q, smp;
    logic [31:0]          sin_q;
    logic [STAGES:1]      vld_pipe;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable)  state_d = RUN;
            RUN:     if (!bus.enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SINE_GEN_EXT_TICK_EN
    // [0],[1] synchronise the codec clock, [2] holds the previous synced level
    logic [2:0] lrck_sync;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) lrck_sync <= '0;
        else                lrck_sync <= {lrck_sync[1:0], lrck};
    end

    assign tick = (state_q == RUN) && lrck_sync[1] && !lrck_sync[2];
`else
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    logic [CNT_W-1:0] cnt;
    logic             unused_lrck;

    assign unused_lrck = lrck;
    assign tick        = (state_q == RUN) && (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || state_q != RUN || tick) cnt <= '0;
        else                                          cnt <= cnt + 1'b1;
    end
`endif

    // Stage 0: latch pre-increment phase; clear wins over a coincident tick
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            phase  <= '0;
            inc    <= '0;
            ph_lat <= '0;
        end else begin
            if (bus.freq_load) inc <= bus.freq_word;
            if (bus.phase_clr) phase <= '0;
            else if (tick)     phase <= phase + inc;
            if (tick)          ph_lat <= phase[PHASE_W-1 -: ROM_AW+2];
        end
    end

    // Stage 1: odd quadrants walk the quarter table backwards
    assign quad = ph_lat[ROM_AW+1 -: 2];
    assign addr = ph_lat[ROM_AW-1:0] ^ {ROM_AW{quad[0]}};

    sine_rom #(.ROM_AW(ROM_AW)) u_rom (
        .clk  (clk_clk),
        .addr (addr),
        .data (rom_q)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) quad_q <= '0;
        else                quad_q <= quad;
    end

    // Stage 3: lower half-wave is the negated table value
    assign smp = quad_q[1] ? sample_t'(-rom_q) : rom_q;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            vld_pipe <= '0;
            sin_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], tick};
            if (vld_pipe[STAGES-1]) sin_q <= {smp, smp};
        end
    end

    assign bus.sin_out      = sin_q;
    assign bus.sample_valid = vld_pipe[STAGES];
endmodule
